module_test_vector_seq: RTL and testbench
=========================================

Name: module_test_vector_seq

Overview:
- Synthesizable stimulus/response sequencer for module-level hardware tests.
- Drives the DUT input vector from a programmable step table. Each step holds one vector for a programmed number of cycles.
- Checks the DUT output vector against a masked expected value at the end of every step.
- Replaces hand-written fixed-delay stimulus with a parametrised, loopable, self-checking engine that sits between the test wrapper and the module under test.

Parameters:
- g_in_bits, 30, width of the stimulus vector driven to the DUT.
- g_out_bits, 30, width of the DUT response vector.
- g_num_steps, 16, step table depth; must be at least 2.
- g_hold_bits, 16, width of the per-step hold counter.

Ports:
- clk_sys_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  asynchronous active-high reset.
- cfg_we_i  in  1  step table write strobe.
- cfg_addr_i  in  clog2(g_num_steps)  step index to write.
- cfg_vec_i  in  g_in_bits  stimulus vector for the step.
- cfg_hold_i  in  g_hold_bits  hold count; the vector is driven for hold+1 cycles.
- cfg_exp_i  in  g_out_bits  expected response.
- cfg_mask_i  in  g_out_bits  compare mask; 1 = bit is checked.
- cfg_last_i  in  clog2(g_num_steps)  index of the final step.
- loop_i  in  1  1 = restart at step 0 after the last step.
- start_i  in  1  start pulse.
- stop_i  in  1  abort pulse.
- output_vector_i  in  g_out_bits  DUT response.
- input_vector_o  out  g_in_bits  stimulus to the DUT.
- busy_o  out  1  sequence running.
- done_o  out  1  single-cycle pulse at sequence completion.
- step_o  out  clog2(g_num_steps)  current step index.
- err_o  out  1  sticky: at least one mismatch since the last start.
- err_cnt_o  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_step_o  out  clog2(g_num_steps)  step index of the first mismatch.

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset is honoured at any time, including mid-sequence: outputs go to 0 immediately and the table contents are preserved.
- States and transitions:
  - IDLE: start_i=1 and stop_i=0 -> at the next edge, err_cnt_o, err_o and first_err_step_o clear, input_vector_o<=vec[0], hold counter<=hold[0], step_o<=0, busy_o<=1, state RUN.
  - RUN, counter>0: decrement the counter.
  - RUN, counter==0 (last cycle of the step): at this edge, compare (output_vector_i & mask[s]) against (exp[s] & mask[s]).
    - On mismatch: err_cnt_o increments unless already saturated, and err_o<=1. If err_o was 0 before this edge, first_err_step_o<=s.
    - At the same edge, load the next step: vec, hold and step_o. The last step's vector is followed by step 0's vector with no idle gap.
  - After step cfg_last_i, with loop_i=1: continue at step 0; done_o is not pulsed and counters are not cleared.
  - After step cfg_last_i, with loop_i=0: state DONE. input_vector_o holds the last vector.
  - DONE lasts one cycle: done_o=1 and busy_o=0, then IDLE.
- Latency: the first vector appears one cycle after start_i. A non-looping run occupies sum over steps of (hold+1) cycles. done_o asserts the cycle after the final compare.
- stop_i in RUN: at the next edge go to IDLE, busy_o<=0, no done_o, no compare for the partial step. input_vector_o holds its current value.
- start_i and stop_i together in IDLE: stop wins and the block stays IDLE.
- start_i while busy: ignored.
- cfg_we_i while busy: the write is dropped. Table writes in IDLE take effect for the next start.
- cfg_last_i and loop_i are sampled at start only. A value of cfg_last_i >= g_num_steps is clamped to g_num_steps-1.
- cfg_hold_i at its maximum value gives 2^g_hold_bits cycles; the counter does not wrap.
- output_vector_i is treated as synchronous to clk_sys_i; no synchronizer is included.

Test Plan:
- Table {vec 0 hold 21, vec 1 hold 29, vec 10 hold 0}, cfg_last_i=2, masks 0, start -> input_vector_o is 0 for 22 cycles, 1 for 30 cycles, then 10. done_o pulses 54 cycles after start. err_cnt_o=0.
- Same table, mask all ones, exp[1]=5, DUT echoes its input -> err_cnt_o=1, err_o=1, first_err_step_o=1.
- loop_i=1, 2 steps of hold 3, permanent mismatch on step 0, run 80 cycles then stop_i -> err_cnt_o=10, busy_o=0, no done_o.
- Assert rst_i mid-step 1 -> outputs go to 0 immediately. The next start replays the unchanged table from step 0.
- cfg_we_i pulsed while busy, and start_i together with stop_i in IDLE -> table unchanged and the block stays IDLE.
- Force err_cnt to 16'hFFFE with looping mismatches -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/module_test_vector_seq.sv
// module_test_vector_seq: table-driven stimulus/response sequencer.
// Drives a DUT input vector step by step and checks masked responses.
module module_test_vector_seq #(
  parameter int g_in_bits   = 30,
  parameter int g_out_bits  = 30,
  parameter int g_num_steps = 16,
  parameter int g_hold_bits = 16
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_i,
  input  logic                           cfg_we_i,
  input  logic [$clog2(g_num_steps)-1:0] cfg_addr_i,
  input  logic [g_in_bits-1:0]           cfg_vec_i,
  input  logic [g_hold_bits-1:0]         cfg_hold_i,
  input  logic [g_out_bits-1:0]          cfg_exp_i,
  input  logic [g_out_bits-1:0]          cfg_mask_i,
  input  logic [$clog2(g_num_steps)-1:0] cfg_last_i,
  input  logic                           loop_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic [g_out_bits-1:0]          output_vector_i,
  output logic [g_in_bits-1:0]           input_vector_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(g_num_steps)-1:0] step_o,
  output logic                           err_o,
  output logic [15:0]                    err_cnt_o,
  output logic [$clog2(g_num_steps)-1:0] first_err_step_o
);

  localparam int AW = $clog2(g_num_steps);
  localparam logic [g_hold_bits-1:0] HOLD_ONE = 1;
  localparam logic [AW-1:0] STEP_ONE = 1;
  localparam logic [AW-1:0] STEP_MAX = AW'(g_num_steps - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [g_in_bits-1:0]   vec_mem  [g_num_steps];
  logic [g_hold_bits-1:0] hold_mem [g_num_steps];
  logic [g_out_bits-1:0]  exp_mem  [g_num_steps];
  logic [g_out_bits-1:0]  mask_mem [g_num_steps];

  logic [g_in_bits-1:0]   vec_q, vec_d;
  logic [g_hold_bits-1:0] cnt_q, cnt_d;
  logic [AW-1:0]          step_q, step_d;
  logic [AW-1:0]          first_q, first_d;
  logic [AW-1:0]          last_q, last_d;
  logic [15:0]            ecnt_q, ecnt_d;
  logic                   loop_q, loop_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [31:0]            last_ext;
  logic [AW-1:0]          last_clamp;
  logic [AW-1:0]          step_nxt;
  logic                   miss;

  // Table memory is written only outside a run and survives reset.
  always_ff @(posedge clk_sys_i) begin
    if (cfg_we_i && state_q != S_RUN) begin
      vec_mem[cfg_addr_i]  <= cfg_vec_i;
      hold_mem[cfg_addr_i] <= cfg_hold_i;
      exp_mem[cfg_addr_i]  <= cfg_exp_i;
      mask_mem[cfg_addr_i] <= cfg_mask_i;
    end
  end

  // Clamp the final step index into the table range.
  always_comb begin
    last_ext   = 32'(cfg_last_i);
    last_clamp = cfg_last_i;
    if (last_ext >= 32'(g_num_steps)) begin
      last_clamp = STEP_MAX;
    end
  end

  assign step_nxt = (step_q == last_q) ? '0 : step_q + STEP_ONE;
  assign miss = |((output_vector_i ^ exp_mem[step_q]) & mask_mem[step_q]);

  // Next-state, step sequencing and end-of-step response check.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    first_d = first_q;
    last_d  = last_q;
    ecnt_d  = ecnt_q;
    loop_d  = loop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = S_RUN;
          vec_d   = vec_mem[0];
          cnt_d   = hold_mem[0];
          step_d  = '0;
          first_d = '0;
          ecnt_d  = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          last_d  = last_clamp;
          loop_d  = loop_i;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_ONE;
        end else begin
          if (miss) begin
            err_d = 1'b1;
            if (ecnt_q != 16'hFFFF) begin
              ecnt_d = ecnt_q + 16'd1;
            end
            if (!err_q) begin
              first_d = step_q;
            end
          end
          if (step_q == last_q && !loop_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d = step_nxt;
            vec_d  = vec_mem[step_nxt];
            cnt_d  = hold_mem[step_nxt];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      ecnt_q  <= '0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      first_q <= first_d;
      last_q  <= last_d;
      ecnt_q  <= ecnt_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign input_vector_o   = vec_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign step_o           = step_q;
  assign err_o            = err_q;
  assign err_cnt_o        = ecnt_q;
  assign first_err_step_o = first_q;

endmodule

// File: tb/tb_module_test_vector_seq.sv
// tb_module_test_vector_seq: randomized self-checking bench.
// Expected behaviour comes from an expanded per-cycle step timeline.
module tb_module_test_vector_seq;

  localparam int IW = 30;
  localparam int OW = 30;
  localparam int NS = 16;
  localparam int AW = 4;
  localparam int HW = 16;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [IW-1:0] cfg_vec = '0;
  logic [HW-1:0] cfg_hold = '0;
  logic [OW-1:0] cfg_exp = '0;
  logic [OW-1:0] cfg_mask = '0;
  logic [AW-1:0] cfg_last = '0;
  logic          loop_in = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [OW-1:0] resp = '0;
  logic [IW-1:0] in_vec;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;
  logic          err;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IW-1:0] m_vec  [NS];
  int            m_hold [NS];
  logic [OW-1:0] m_exp  [NS];
  logic [OW-1:0] m_mask [NS];
  int            m_cnt;
  bit            m_err;
  int            m_first;

  always #5 clk_sys = ~clk_sys;

  module_test_vector_seq #(
    .g_in_bits(IW),
    .g_out_bits(OW),
    .g_num_steps(NS),
    .g_hold_bits(HW)
  ) dut (
    .clk_sys_i(clk_sys),
    .rst_i(rst),
    .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr),
    .cfg_vec_i(cfg_vec),
    .cfg_hold_i(cfg_hold),
    .cfg_exp_i(cfg_exp),
    .cfg_mask_i(cfg_mask),
    .cfg_last_i(cfg_last),
    .loop_i(loop_in),
    .start_i(start),
    .stop_i(stop),
    .output_vector_i(resp),
    .input_vector_o(in_vec),
    .busy_o(busy),
    .done_o(done),
    .step_o(step),
    .err_o(err),
    .err_cnt_o(err_cnt),
    .first_err_step_o(first_err)
  );

  task automatic write_step(input int a, input logic [IW-1:0] v,
                            input int h, input logic [OW-1:0] e,
                            input logic [OW-1:0] m);
    @(negedge clk_sys);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_vec = v;
    cfg_hold = HW'(h);
    cfg_exp = e;
    cfg_mask = m;
    @(negedge clk_sys);
    cfg_we = 1'b0;
    m_vec[a] = v;
    m_hold[a] = h;
    m_exp[a] = e;
    m_mask[a] = m;
  endtask

  // Start a run, follow the expanded timeline cycle by cycle.
  // mode 0: response echoes the stimulus; mode 1: random response.
  task automatic run_seq(input int last, input bit lp,
                         input int stop_at, input int mode);
    int tl[$];
    bit te[$];
    int L;
    int s;
    int k;
    logic [IW-1:0] ev;
    for (int i = 0; i <= last; i++) begin
      for (int j = 0; j <= m_hold[i]; j++) begin
        tl.push_back(i);
        te.push_back(j == m_hold[i]);
      end
    end
    L = tl.size();
    @(negedge clk_sys);
    cfg_last = AW'(last);
    loop_in = lp;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    m_first = 0;
    k = 0;
    forever begin
      if (!lp && k == L) break;
      s = tl[k % L];
      ev = m_vec[s];
      n_cmp++;
      if (in_vec !== ev || step !== AW'(s) || busy !== 1'b1 ||
          done !== 1'b0) begin
        n_bad++;
        $display("FAIL run cyc %0d: vec %h step %0d busy %b done %b, want %h %0d 1 0",
                 k, in_vec, step, busy, done, ev, s);
      end
      n_cmp++;
      if (err_cnt !== 16'(m_cnt) || err !== m_err ||
          first_err !== AW'(m_first)) begin
        n_bad++;
        $display("FAIL run err cyc %0d: cnt %0d err %b first %0d, want %0d %b %0d",
                 k, err_cnt, err, first_err, m_cnt, m_err, m_first);
      end
      resp = (mode == 0) ? ev : OW'($urandom);
      if (lp && k == stop_at) begin
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        break;
      end
      if (te[k % L] && ((resp ^ m_exp[s]) & m_mask[s]) != '0) begin
        if (!m_err) m_first = s;
        m_err = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      k++;
      @(negedge clk_sys);
    end
    ev = lp ? m_vec[tl[stop_at % L]] : m_vec[last];
    n_cmp++;
    if (done !== !lp || busy !== 1'b0 || in_vec !== ev) begin
      n_bad++;
      $display("FAIL end: done %b busy %b vec %h, want %b 0 %h",
               done, busy, in_vec, !lp, ev);
    end
    n_cmp++;
    if (err_cnt !== 16'(m_cnt) || err !== m_err ||
        first_err !== AW'(m_first)) begin
      n_bad++;
      $display("FAIL end err: cnt %0d err %b first %0d, want %0d %b %0d",
               err_cnt, err, first_err, m_cnt, m_err, m_first);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post: done %b busy %b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (in_vec !== '0 || busy !== 1'b0 || done !== 1'b0 || step !== '0 ||
        err !== 1'b0 || err_cnt !== '0 || first_err !== '0) begin
      n_bad++;
      $display("FAIL reset: vec %h busy %b done %b step %0d err %b cnt %0d first %0d, want all 0",
               in_vec, busy, done, step, err, err_cnt, first_err);
    end
    @(negedge clk_sys);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    write_step(0, 30'd0, 21, '0, '0);
    write_step(1, 30'd1, 29, '0, '0);
    write_step(2, 30'd10, 0, '0, '0);
    run_seq(2, 1'b0, 0, 1);
    n_cmp++;
    if (err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL basic cnt: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_mismatch;
    write_step(0, 30'd0, 21, 30'd0, '1);
    write_step(1, 30'd1, 29, 30'd5, '1);
    write_step(2, 30'd10, 0, 30'd10, '1);
    run_seq(2, 1'b0, 0, 0);
    n_cmp++;
    if (err_cnt !== 16'd1 || err !== 1'b1 || first_err !== 4'd1) begin
      n_bad++;
      $display("FAIL mismatch: cnt %0d err %b first %0d, want 1 1 1",
               err_cnt, err, first_err);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_sys);
    cfg_last = 4'd2;
    loop_in = 1'b0;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (25) @(negedge clk_sys);
    n_cmp++;
    if (busy !== 1'b1 || step !== 4'd1 || in_vec !== 30'd1) begin
      n_bad++;
      $display("FAIL pre-reset: busy %b step %0d vec %h, want 1 1 1",
               busy, step, in_vec);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (in_vec !== '0 || busy !== 1'b0 || done !== 1'b0 || step !== '0 ||
        err !== 1'b0 || err_cnt !== '0 || first_err !== '0) begin
      n_bad++;
      $display("FAIL mid reset: vec %h busy %b step %0d cnt %0d, want all 0",
               in_vec, busy, step, err_cnt);
    end
    @(negedge clk_sys);
    rst = 1'b0;
    run_seq(2, 1'b0, 0, 0);
  endtask

  task automatic test_cfg_busy;
    @(negedge clk_sys);
    cfg_last = 4'd2;
    loop_in = 1'b1;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_vec = 30'h3ABCDEF0;
    cfg_hold = 16'd2;
    cfg_exp = '0;
    cfg_mask = '0;
    @(negedge clk_sys);
    cfg_addr = 4'd1;
    @(negedge clk_sys);
    cfg_we = 1'b0;
    stop = 1'b1;
    @(negedge clk_sys);
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL stop: busy %b done %b, want 0 0", busy, done);
    end
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || in_vec !== 30'd0) begin
        n_bad++;
        $display("FAIL start+stop cyc %0d: busy %b vec %h, want 0 0",
                 i, busy, in_vec);
      end
      @(negedge clk_sys);
    end
    run_seq(2, 1'b0, 0, 0);
  endtask

  task automatic test_loop_stop;
    logic [IW-1:0] v0;
    v0 = IW'($urandom);
    write_step(0, v0, 3, ~v0, '1);
    write_step(1, IW'($urandom), 3, '0, '0);
    run_seq(1, 1'b1, 80, 0);
    n_cmp++;
    if (err_cnt !== 16'd10 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL loop stop: cnt %0d busy %b, want 10 0", err_cnt, busy);
    end
  endtask

  task automatic test_random;
    int last;
    logic [IW-1:0] v;
    for (int it = 0; it < 6; it++) begin
      last = $urandom_range(1, NS - 1);
      for (int i = 0; i <= last; i++) begin
        v = IW'($urandom);
        write_step(i, v, $urandom_range(0, 4),
                   v ^ (OW'($urandom) & OW'($urandom) & OW'($urandom)),
                   OW'($urandom));
      end
      if (it < 4) run_seq(last, 1'b0, 0, it % 2);
      else run_seq(last, 1'b1, $urandom_range(5, 60), 0);
    end
  endtask

  task automatic test_saturate;
    logic [IW-1:0] v;
    v = IW'($urandom);
    write_step(0, v, 0, ~v, '1);
    write_step(1, ~v, 0, v, '1);
    run_seq(1, 1'b1, 65540, 0);
    n_cmp++;
    if (err_cnt !== 16'hFFFF || err !== 1'b1 || first_err !== 4'd0) begin
      n_bad++;
      $display("FAIL saturate: cnt %h err %b first %0d, want ffff 1 0",
               err_cnt, err, first_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_reset_mid();
    test_cfg_busy();
    test_loop_stop();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
